mips32_prog_loader: RTL

//  Boot-time program loader sitting directly upstream of the MIPS32 pipelined core.

---
 rtl/mips32_pkg.sv | 15 +
 rtl/mips32_prog_loader.sv | 110 +++++++++++
 2 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 boot loader and core: loader state encoding and the HLT opcode.
package mips32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [5:0]  HLT_OP = 6'h3f;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LOAD,
        LDR_RELEASE,
        LDR_RUN,
        LDR_ERROR
    } ldr_state_t;

endpackage

// File: rtl/mips32_prog_loader.sv
// Boot-time program loader: streams words into instruction memory, then releases the core until HLT.
// Optional MIPS32_LDR_CHECKSUM_EN: the s_last beat carries an XOR checksum and is not written.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_pc_clr,
    output logic              core_run,
    input  logic              core_halted,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    ldr_state_t      state, state_nxt;
    logic            accepting;
    logic            beat;
    logic            ovf;
    logic            wr_go;
    logic [ADDR_W:0] cnt_base;

    assign accepting = (state == LDR_IDLE) || (state == LDR_LOAD);
    // Gated by rst_n so s_ready reads 0 while reset is held, like every other output.
    assign s_ready   = rst_n && accepting;
    assign beat      = s_valid && accepting;
    assign cnt_base  = (state == LDR_IDLE) ? '0 : word_count;
    assign ovf       = beat && (state == LDR_LOAD) && (word_count == (ADDR_W+1)'(MAX_WORDS));

`ifdef MIPS32_LDR_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    assign wr_go = beat && !ovf && !s_last;
`else
    assign wr_go = beat && !ovf;
`endif

    assign core_pc_clr = (state == LDR_RELEASE);
    assign core_run    = (state == LDR_RUN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            LDR_IDLE, LDR_LOAD: begin
                if (beat) begin
                    if (ovf)
                        state_nxt = LDR_ERROR;
`ifdef MIPS32_LDR_CHECKSUM_EN
                    // A checksum beat in IDLE means an empty program: reject it.
                    else if (s_last)
                        state_nxt = (state == LDR_LOAD && s_data == csum) ? LDR_RELEASE : LDR_ERROR;
`else
                    else if (s_last)
                        state_nxt = LDR_RELEASE;
`endif
                    else
                        state_nxt = LDR_LOAD;
                end
            end
            LDR_RELEASE: state_nxt = LDR_RUN;
            LDR_RUN:     if (core_halted) state_nxt = LDR_IDLE;
            LDR_ERROR:   state_nxt = LDR_ERROR;
            default:     state_nxt = LDR_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LDR_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_we <= wr_go;
            done   <= (state == LDR_RUN) && core_halted;
            if (wr_go) begin
                mem_addr  <= ADDR_W'(BASE_ADDR) + cnt_base[ADDR_W-1:0];
                mem_wdata <= s_data;
            end
            if (beat && !ovf)
                word_count <= cnt_base + (ADDR_W+1)'(wr_go);
            if (state_nxt == LDR_ERROR)
                err <= 1'b1;
        end
    end

`ifdef MIPS32_LDR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= '0;
        else if (wr_go)
            csum <= (state == LDR_IDLE) ? s_data : (csum ^ s_data);
    end
`endif

endmodule
